// File: rtl/fup_prom_func_pkg.sv
// Shared constants and types for the 4x2 fuse-PROM function generator.
package fup_prom_func_pkg;
    localparam int FUP_DEPTH  = 4;
    localparam int FUP_WORD_W = 2;

    typedef logic [FUP_WORD_W-1:0] fup_word_t;

    // {word3, word2, word1, word0}, each word {F2, F1}: half adder
    localparam logic [FUP_DEPTH*FUP_WORD_W-1:0] FUP_HALF_ADDER_INIT = 8'b10_01_01_00;

    localparam int F1_BIT = 0;
    localparam int F2_BIT = 1;
endpackage

// File: rtl/fup_prom_func_fuse_array.sv
// 4x2 fuse storage: loads INIT on reset, bits can only be cleared, lockable.
module fup_fuse_array
    import fup_prom_func_pkg::*;
#(
    parameter logic [FUP_DEPTH*FUP_WORD_W-1:0] INIT = FUP_HALF_ADDER_INIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       prog_we_i,
    input  logic [1:0] prog_addr_i,
    input  fup_word_t  prog_blow_i,
    input  logic       lock_i,
    input  logic [1:0] rd_addr_i,
    output fup_word_t  rd_word_o,
    output logic       locked_o
);
    logic [FUP_DEPTH-1:0][FUP_WORD_W-1:0] mem_q, mem_d;
    logic                                 locked_q, locked_d;

    // Write gating uses the lock state before this edge, so a write
    // issued together with lock still lands.
    always_comb begin
        mem_d    = mem_q;
        locked_d = locked_q | lock_i;
        if (prog_we_i && !locked_q)
            mem_d[prog_addr_i] = mem_q[prog_addr_i] & ~prog_blow_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= INIT;
            locked_q <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            locked_q <= locked_d;
        end
    end

    assign rd_word_o = mem_q[rd_addr_i];
    assign locked_o  = locked_q;
endmodule

// File: rtl/fup_prom_func.sv
// Two-output 2-input function generator: fuse PROM lookup with registered outputs.
module fup_prom_func
    import fup_prom_func_pkg::*;
#(
    parameter logic [7:0] INIT = FUP_HALF_ADDER_INIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] A,
    input  logic       prog_we,
    input  logic [1:0] prog_addr,
    input  logic [1:0] prog_blow,
    input  logic       lock,
    output logic       locked,
    output logic       F1,
    output logic       F2
);
    fup_word_t rd_word;
    fup_word_t f_q, f_d;

    fup_fuse_array #(.INIT(INIT)) u_array (
        .clk         (clk),
        .rst         (rst),
        .prog_we_i   (prog_we),
        .prog_addr_i (prog_addr),
        .prog_blow_i (prog_blow),
        .lock_i      (lock),
        .rd_addr_i   (A),
        .rd_word_o   (rd_word),
        .locked_o    (locked)
    );

    // rd_word reflects pre-edge contents, giving read-before-write.
    assign f_d = en ? rd_word : '0;

    always_ff @(posedge clk) begin
        if (rst) f_q <= '0;
        else     f_q <= f_d;
    end

    assign F1 = f_q[F1_BIT];
    assign F2 = f_q[F2_BIT];
endmodule

// File: tb/tb_fup_prom_func.sv
// Directed scoreboard bench for fup_prom_func: driver queues expectations, monitor checks.
module tb_fup_prom_func;
    logic       clk = 1'b0;
    logic       rst, en, prog_we, lock;
    logic [1:0] A, prog_addr, prog_blow;
    logic       locked, F1, F2;

    typedef struct {
        string      name;
        logic [2:0] exp;   // {locked, F2, F1}
    } exp_t;

    exp_t sb[$];
    int   n_pass = 0;
    int   n_total = 0;

    fup_prom_func dut (
        .clk(clk), .rst(rst), .en(en), .A(A),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_blow(prog_blow),
        .lock(lock), .locked(locked), .F1(F1), .F2(F2)
    );

    always #5 clk = ~clk;

    // Monitor: each edge with a pending expectation is compared.
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_total++;
            if ({locked, F2, F1} === e.exp) n_pass++;
            else $display("FAIL %s: got {locked,F2,F1}=%b, expected %b", e.name, {locked, F2, F1}, e.exp);
        end
    end

    task automatic step(input string nm, input logic r, input logic e, input logic [1:0] a,
                        input logic we, input logic [1:0] pa, input logic [1:0] pb,
                        input logic lk, input logic l_exp, input logic [1:0] f_exp);
        exp_t x;
        @(negedge clk);
        rst = r; en = e; A = a; prog_we = we; prog_addr = pa; prog_blow = pb; lock = lk;
        x.name = nm;
        x.exp  = {l_exp, f_exp};
        sb.push_back(x);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; A = 2'b00; prog_we = 1'b0;
        prog_addr = 2'b00; prog_blow = 2'b00; lock = 1'b0;
        //    name            rst en A    we pa   pb    lk  L   {F2,F1}
        step("reset",         1, 0, 2'd0, 0, 2'd0, 2'b00, 0, 0, 2'b00);
        step("en0_idle",      0, 0, 2'd3, 0, 2'd0, 2'b00, 0, 0, 2'b00);
        step("sweep_a0",      0, 1, 2'd0, 0, 2'd0, 2'b00, 0, 0, 2'b00);
        step("sweep_a1",      0, 1, 2'd1, 0, 2'd0, 2'b00, 0, 0, 2'b01);
        step("sweep_a2",      0, 1, 2'd2, 0, 2'd0, 2'b00, 0, 0, 2'b01);
        step("sweep_a3",      0, 1, 2'd3, 0, 2'd0, 2'b00, 0, 0, 2'b10);
        step("en0_mid_a1",    0, 0, 2'd1, 0, 2'd0, 2'b00, 0, 0, 2'b00);
        step("reen_a1",       0, 1, 2'd1, 0, 2'd0, 2'b00, 0, 0, 2'b01);
        step("prog_w2_b01",   0, 1, 2'd0, 1, 2'd2, 2'b01, 0, 0, 2'b00);
        step("read_w2_blown", 0, 1, 2'd2, 0, 2'd0, 2'b00, 0, 0, 2'b00);
        step("rbw_w3_old",    0, 1, 2'd3, 1, 2'd3, 2'b10, 0, 0, 2'b10);
        step("rbw_w3_new",    0, 1, 2'd3, 0, 2'd0, 2'b00, 0, 0, 2'b00);
        step("blow_w0_zero",  0, 1, 2'd0, 1, 2'd0, 2'b11, 0, 0, 2'b00);
        step("read_w0",       0, 1, 2'd0, 0, 2'd0, 2'b00, 0, 0, 2'b00);
        step("blow00_w1",     0, 0, 2'd1, 1, 2'd1, 2'b00, 0, 0, 2'b00);
        step("read_w1_keep",  0, 1, 2'd1, 0, 2'd0, 2'b00, 0, 0, 2'b01);
        step("lock",          0, 1, 2'd1, 0, 2'd0, 2'b00, 1, 1, 2'b01);
        step("prog_locked",   0, 1, 2'd1, 1, 2'd1, 2'b11, 0, 1, 2'b01);
        step("read_locked",   0, 1, 2'd1, 0, 2'd0, 2'b00, 0, 1, 2'b01);
        step("rst_restore",   1, 1, 2'd1, 0, 2'd0, 2'b00, 0, 0, 2'b00);
        step("read_w2_init",  0, 1, 2'd2, 0, 2'd0, 2'b00, 0, 0, 2'b01);
        step("lock_and_prog", 0, 1, 2'd1, 1, 2'd1, 2'b01, 1, 1, 2'b01);
        step("lock_prog_app", 0, 1, 2'd1, 0, 2'd0, 2'b00, 0, 1, 2'b00);
        step("rst_priority",  1, 1, 2'd3, 1, 2'd3, 2'b11, 1, 0, 2'b00);
        step("read_w3_init",  0, 1, 2'd3, 0, 2'd0, 2'b00, 0, 0, 2'b10);
        step("read_w1_init",  0, 1, 2'd1, 0, 2'd0, 2'b00, 0, 0, 2'b01);
        @(negedge clk);
        en = 1'b0; prog_we = 1'b0; lock = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            n_total++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
